// File: rtl/cdb_arbiter_buf_if.sv
// Common data bus front-end port bundle: producer push side plus registered broadcast side.
// The master modport is the producer/consumer environment; the slave modport is the bus buffer.
interface cdb_arbiter_buf_if #(
   parameter int N_CH = 4,
   parameter int DW   = 32,
   parameter int LW   = 4
);
   logic [N_CH-1:0]    require;
   logic [N_CH*DW-1:0] dataIn;
   logic [N_CH*LW-1:0] labelIn;
   logic [N_CH-1:0]    accept;
   logic [N_CH-1:0]    full;
   logic               BCEN;
   logic [DW-1:0]      BCdata;
   logic [LW-1:0]      BClabel;

   modport master (
      output require, dataIn, labelIn,
      input  accept, full, BCEN, BCdata, BClabel
   );

   modport slave (
      input  require, dataIn, labelIn,
      output accept, full, BCEN, BCdata, BClabel
   );
endinterface

// File: rtl/cdb_arbiter_buf.sv
// Buffered common data bus: per-unit result FIFOs feeding a one-per-cycle arbiter
// that drives the registered BCEN/BCdata/BClabel broadcast.

module cdb_ch_fifo #(
   parameter int DEPTH = 2,
   parameter int DW    = 32,
   parameter int LW    = 4
) (
   input  logic          clk,
   input  logic          nRST,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   input  logic [LW-1:0] lin,
   output logic          empty,
   output logic          full,
   output logic [DW-1:0] dout,
   output logic [LW-1:0] lout
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_d [DEPTH];
   logic [LW-1:0] mem_l [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_nxt(wr_ptr);
         if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
         // push+pop together leaves the occupancy unchanged
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_d[wr_ptr] <= din;
         mem_l[wr_ptr] <= lin;
      end
   end

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign dout  = mem_d[rd_ptr];
   assign lout  = mem_l[rd_ptr];
endmodule

module cdb_arbiter_buf #(
   parameter int N_CH      = 4,
   parameter int DEPTH     = 2,
   parameter int DW        = 32,
   parameter int LW        = 4,
   parameter int PRIO_MODE = 0
) (
   input  logic               clk,
   input  logic               nRST,
   cdb_arbiter_buf_if.slave   bus
);
   localparam int GW = $clog2(N_CH);

   logic [N_CH-1:0]          empty, full_v, push, pop;
   logic [N_CH-1:0][DW-1:0]  head_d;
   logic [N_CH-1:0][LW-1:0]  head_l;
   logic [GW-1:0]            rr_ptr, gnt;
   logic                     gnt_vld;
   logic                     bc_en;
   logic [DW-1:0]            bc_data;
   logic [LW-1:0]            bc_label;

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_ch
         // label 0 marks "no result" and never enters the buffer
         assign push[g] = bus.require[g] && !full_v[g] && (bus.labelIn[g*LW +: LW] != '0);
         assign pop[g]  = gnt_vld && (gnt == GW'(g));

         cdb_ch_fifo #(.DEPTH(DEPTH), .DW(DW), .LW(LW)) u_fifo (
            .clk   (clk),
            .nRST  (nRST),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (bus.dataIn[g*DW +: DW]),
            .lin   (bus.labelIn[g*LW +: LW]),
            .empty (empty[g]),
            .full  (full_v[g]),
            .dout  (head_d[g]),
            .lout  (head_l[g])
         );
      end
   endgenerate

   // Search order: fixed 0..N_CH-1, or rotated to start at rr_ptr.
   function automatic int slot(input int k, input logic [GW-1:0] p);
      if (PRIO_MODE != 0) return k;
      return (int'(p) + k) % N_CH;
   endfunction

   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (!gnt_vld && !empty[slot(k, rr_ptr)]) begin
            gnt_vld = 1'b1;
            gnt     = GW'(slot(k, rr_ptr));
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rr_ptr   <= '0;
         bc_en    <= 1'b0;
         bc_data  <= '0;
         bc_label <= '0;
      end else begin
         bc_en <= gnt_vld;
         if (gnt_vld) begin
            bc_data  <= head_d[gnt];
            bc_label <= head_l[gnt];
            if (PRIO_MODE == 0) rr_ptr <= (gnt == GW'(N_CH - 1)) ? '0 : gnt + 1'b1;
         end
      end
   end

   assign bus.accept  = push;
   assign bus.full    = full_v;
   assign bus.BCEN    = bc_en;
   assign bus.BCdata  = bc_data;
   assign bus.BClabel = bc_label;
endmodule

// File: tb/tb_cdb_arbiter_buf.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and
// scoreboards each broadcast against a queue-based model of the buffer.
module tb_cdb_arbiter_buf;
   localparam int N  = 4;
   localparam int D  = 2;
   localparam int DW = 32;
   localparam int LW = 4;

   typedef logic [N-1:0][LW-1:0] lv_t;
   typedef logic [N-1:0][DW-1:0] dv_t;
   typedef struct {logic [LW-1:0] lbl; logic [DW-1:0] dat;} ent_t;
   typedef struct {int cyc; logic [LW-1:0] lbl; logic [DW-1:0] dat;} exp_t;

   logic clk = 1'b0;
   logic nRST = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] req = '0;
   lv_t          lin = '0;
   dv_t          din = '0;

   cdb_arbiter_buf_if #(.N_CH(N), .DW(DW), .LW(LW)) bus_rr ();
   cdb_arbiter_buf_if #(.N_CH(N), .DW(DW), .LW(LW)) bus_fp ();

   cdb_arbiter_buf #(.N_CH(N), .DEPTH(D), .DW(DW), .LW(LW), .PRIO_MODE(0)) u_rr (
      .clk(clk), .nRST(nRST), .bus(bus_rr.slave));
   cdb_arbiter_buf #(.N_CH(N), .DEPTH(D), .DW(DW), .LW(LW), .PRIO_MODE(1)) u_fp (
      .clk(clk), .nRST(nRST), .bus(bus_fp.slave));

   assign bus_rr.require = req;
   assign bus_rr.labelIn = lin;
   assign bus_rr.dataIn  = din;
   assign bus_fp.require = req;
   assign bus_fp.labelIn = lin;
   assign bus_fp.dataIn  = din;

   logic [1:0]               bc_en;
   logic [1:0][DW-1:0]       bc_d;
   logic [1:0][LW-1:0]       bc_l;
   logic [1:0][N-1:0]        acc, ful;
   assign bc_en = {bus_fp.BCEN, bus_rr.BCEN};
   assign bc_d  = {bus_fp.BCdata, bus_rr.BCdata};
   assign bc_l  = {bus_fp.BClabel, bus_rr.BClabel};
   assign acc   = {bus_fp.accept, bus_rr.accept};
   assign ful   = {bus_fp.full, bus_rr.full};

   // Model state: one queue per channel per mode, plus expected broadcasts.
   ent_t          mq [2][N][$];
   exp_t          sb [2][$];
   int            rr_m [2];
   logic [DW-1:0] held_d [2];
   logic [LW-1:0] held_l [2];
   string         mn [2] = '{"rr", "fp"};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step(input int m, output logic [N-1:0] ea, output logic [N-1:0] ef);
      int   w;
      int   c;
      ent_t e;
      exp_t x;
      w = -1;
      for (int i = 0; i < N; i++) begin
         ef[i] = (mq[m][i].size() == D);
         ea[i] = req[i] && !ef[i] && (lin[i] != '0);
      end
      for (int k = 0; k < N; k++) begin
         c = (m == 1) ? k : (rr_m[m] + k) % N;
         if (w < 0 && mq[m][c].size() > 0) w = c;
      end
      if (w >= 0) begin
         e = mq[m][w].pop_front();
         x.cyc = cyc + 1;
         x.lbl = e.lbl;
         x.dat = e.dat;
         sb[m].push_back(x);
         if (m == 0) rr_m[0] = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (ea[i]) begin
            e.lbl = lin[i];
            e.dat = din[i];
            mq[m][i].push_back(e);
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input lv_t l, input dv_t d);
      logic [1:0][N-1:0] ea, ef;
      @(posedge clk);
      #1;
      req = r;
      lin = l;
      din = d;
      for (int m = 0; m < 2; m++) model_step(m, ea[m], ef[m]);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk({mn[m], "_accept"}, 64'(acc[m]), 64'(ea[m]));
         chk({mn[m], "_full"}, 64'(ful[m]), 64'(ef[m]));
      end
   endtask

   task automatic step_r(input logic [N-1:0] r, input lv_t l);
      dv_t d;
      for (int i = 0; i < N; i++) d[i] = $urandom;
      step(r, l, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, '0, '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      nRST = 1'b0;
      req  = '0;
      for (int m = 0; m < 2; m++) begin
         sb[m].delete();
         for (int i = 0; i < N; i++) mq[m][i].delete();
         rr_m[m]   = 0;
         held_d[m] = '0;
         held_l[m] = '0;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
         chk({mn[m], "_rst_bcen"}, 64'(bc_en[m]), 64'(0));
         chk({mn[m], "_rst_bcdata"}, 64'(bc_d[m]), 64'(0));
         chk({mn[m], "_rst_bclabel"}, 64'(bc_l[m]), 64'(0));
         chk({mn[m], "_rst_full"}, 64'(ful[m]), 64'(0));
      end
      repeat (2) @(posedge clk);
      #1;
      nRST = 1'b1;
   endtask

   // Monitor: every cycle out of reset, BCEN must match whether a broadcast is due now.
   bit   mon_ev;
   exp_t mon_e;
   always @(negedge clk) begin
      if (nRST) begin
         for (int m = 0; m < 2; m++) begin
            mon_ev = (sb[m].size() > 0) && (sb[m][0].cyc == cyc);
            chk({mn[m], "_bcen"}, 64'(bc_en[m]), 64'(mon_ev));
            if (mon_ev) begin
               mon_e = sb[m].pop_front();
               chk({mn[m], "_bclabel"}, 64'(bc_l[m]), 64'(mon_e.lbl));
               chk({mn[m], "_bcdata"}, 64'(bc_d[m]), 64'(mon_e.dat));
               held_d[m] = mon_e.dat;
               held_l[m] = mon_e.lbl;
            end else begin
               chk({mn[m], "_hold_label"}, 64'(bc_l[m]), 64'(held_l[m]));
               chk({mn[m], "_hold_data"}, 64'(bc_d[m]), 64'(held_d[m]));
            end
         end
      end
   end

   initial begin
      lv_t l;
      dv_t d;
      do_reset();
      idle(2);

      // single-channel latency: ch1, data 0xAA, label 5
      l = '0; d = '0; l[1] = 4'd5; d[1] = 32'h0000_00AA;
      step(4'b0010, l, d);
      idle(4);

      // four-way contention then a second ch0 entry
      step_r(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1});
      step_r(4'b0001, {4'd0, 4'd0, 4'd0, 4'd6});
      idle(7);

      // ch0 fed continuously, ch2 pushed once with label 7
      for (int k = 0; k < 8; k++) begin
         l = '0;
         l[0] = (k % 2 == 0) ? 4'd1 : 4'd2;
         l[2] = 4'd7;
         step_r((k == 1) ? 4'b0101 : 4'b0001, l);
      end
      idle(5);

      // ch3 backpressure while ch0 keeps winning in fixed priority
      for (int k = 0; k < 3; k++) step_r(4'b1001, {4'(8 + k), 4'd0, 4'd0, 4'd3});
      idle(7);

      // reset with three entries buffered, then quiet cycles
      step_r(4'b0111, {4'd0, 4'd9, 4'd10, 4'd11});
      do_reset();
      idle(3);

      // label 0 ignored, then five spaced pushes through ch2 to wrap pointers
      step_r(4'b0100, '0);
      idle(2);
      for (int k = 1; k <= 5; k++) begin
         l = '0;
         l[2] = 4'(k);
         step_r(4'b0100, l);
         idle(1);
      end
      idle(3);

      // random traffic with one reset in the middle
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < N; i++) l[i] = 4'($urandom_range(0, 15));
         step_r(4'($urandom_range(0, 15)), l);
         if (k == 250) do_reset();
      end
      idle(8);

      for (int m = 0; m < 2; m++) chk({mn[m], "_drained"}, 64'(sb[m].size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter_buf.md
Name: cdb_arbiter_buf

Overview:
Parametrised common data bus front-end for the Tomasulo core, replacing the combinational require/accept bus pairing. Each functional unit deposits its result and label into a private per-channel FIFO, so units are never stalled waiting for bus grant. One entry per cycle is selected from the non-empty FIFO heads, by round-robin or fixed priority. The selected entry is broadcast on registered BCEN/BCdata/BClabel to the reservation stations and register file.

Parameters:
N_CH, 4, number of producer channels (functional units); 2..8.
DEPTH, 2, entries per channel FIFO; power of two, 1..8.
DW, 32, data width.
LW, 4, label width; label value 0 means "no label" and is never broadcast.
PRIO_MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (channel 0 highest).

Ports:
clk  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
require  in  N_CH  per-channel push request; the entry is presented this cycle.
dataIn  in  N_CH*DW  flattened result data; channel i occupies bits [i*DW +: DW].
labelIn  in  N_CH*LW  flattened result labels; channel i occupies bits [i*LW +: LW].
accept  out  N_CH  per-channel push accepted this cycle (combinational).
full  out  N_CH  per-channel FIFO full (from registered count).
BCEN  out  1  broadcast valid (registered).
BCdata  out  DW  broadcast data (registered).
BClabel  out  LW  broadcast label (registered).

Behaviour:
- Reset (nRST low, asynchronous):
  - All FIFOs empty; read/write pointers and counts are 0.
  - rr_ptr = 0.
  - BCEN = 0, BCdata = 0, BClabel = 0.
  - Reset mid-operation discards all buffered entries; nothing is broadcast until after the first push following release.
- Push (per channel i):
  - accept[i] = require[i] && !full[i] && labelIn_i != 0.
  - On accept, data and label are written at the rising edge.
  - full is computed from the pre-edge count. A push into a full FIFO is rejected even if that FIFO pops in the same cycle.
  - A require with label 0 is ignored: no write, accept low.
- Simultaneous push and pop on one non-full FIFO: both happen and the count is unchanged.
  - With DEPTH = 1, push and pop in the same cycle require the FIFO to be non-full, so this case cannot arise.
- Arbitration, each cycle, over the set of non-empty FIFO heads:
  - PRIO_MODE = 0: search channels rr_ptr, rr_ptr+1, ... modulo N_CH. The first non-empty channel g wins, and rr_ptr becomes (g+1) mod N_CH at the edge. With no candidate, rr_ptr is held.
  - PRIO_MODE = 1: the lowest-index non-empty channel wins; rr_ptr is unused and stays 0.
  - The winner's head is popped at the edge.
- Broadcast:
  - At the same edge: BCEN <= (winner exists), BCdata <= head data, BClabel <= head label.
  - With no winner: BCEN <= 0. BCdata and BClabel are held; consumers must qualify them with BCEN.
- Latency:
  - An entry accepted in cycle t is earliest at the FIFO head in cycle t+1.
  - It is broadcast visible in cycle t+2; there is no same-cycle bypass.
  - Throughput is one broadcast per cycle total.
- Ordering: entries within one channel are broadcast in FIFO order. No ordering guarantee across channels beyond the arbitration rule.
- Fairness: in round-robin mode, a continuously non-empty channel waits at most N_CH-1 broadcasts.
- Wrap-around: FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Test Plan:
1. Reset check (N_CH=4, DEPTH=2): assert nRST low mid-run with 3 entries buffered → BCEN=0, BCdata=0, BClabel=0, full=4'b0000 immediately. No BCEN in the 3 cycles after release without pushes.
2. Single-channel latency: push ch1, data 0x0000_00AA, label 5, in cycle t → accept=4'b0010 in cycle t. BCEN=1, BCdata=0xAA, BClabel=5 in cycle t+2 only.
3. Round-robin contention (PRIO_MODE=0): one cycle pushes ch0..ch3 with labels 1..4; next cycle pushes ch0 with label 6 → broadcast label order 1,2,3,4,6 on consecutive cycles. rr_ptr returns to 1 after the last grant.
4. Fixed priority (PRIO_MODE=1): keep ch0 fed every cycle with labels 1,2,1,2…; push ch2 once with label 7 → label 7 is never broadcast while ch0 stays non-empty. Stop ch0 → label 7 broadcasts 2 cycles after ch0 drains.
5. Full/backpressure (DEPTH=2): push ch3 three consecutive cycles while ch0 is continuously fed and preferred (PRIO_MODE=1) → accept[3]=1,1,0; full[3]=1 from the third cycle. The third entry is not stored.
6. Label-0 and wrap: push ch2 with label 0 → accept[2]=0 and no broadcast. Then push ch2 five entries, labels 1..5, spaced 2 cycles apart → broadcasts 1..5 in order, pointers wrap, no loss.
